// File: rtl/reg_file_pkg.sv
// Shared types and sizing helpers for the integer register file and its scoreboard.
package reg_file_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NUM_REGS_DEF = 32;

  function automatic int unsigned calc_aw(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned AW_DEF = calc_aw(NUM_REGS_DEF);

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: issue increments, writeback decrements,
// saturation back-pressures issue, and a sticky flag records writeback underflow.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned CNT_W    = 2,
  parameter  int unsigned NUM_READ = 2,
  localparam int unsigned AW       = calc_aw(NUM_REGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wb_valid,
  input  logic [AW-1:0]          i_wb_rd,
  input  logic                   i_issue_valid,
  input  logic [AW-1:0]          i_issue_rd,
  input  logic [NUM_READ*AW-1:0] i_rd_addr,
  output logic [NUM_READ-1:0]    o_rd_busy,
  output logic                   o_issue_ready,
  output logic                   o_err_underflow
);

  logic [CNT_W-1:0] r_cnt [NUM_REGS-1:1];
  logic             r_err;

  // Entry 0 is a constant zero so address 0 can index the view directly.
  logic [CNT_W-1:0] w_cnt [NUM_REGS];

  assign w_cnt[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt_view
    assign w_cnt[g] = r_cnt[g];
  end

  logic w_wb_nz;
  logic w_iss_nz;
  logic w_dec;
  logic w_underflow;
  logic w_sat;
  logic w_inc;

  assign w_wb_nz     = i_wb_valid && (i_wb_rd != AW'(REG_ZERO));
  assign w_iss_nz    = i_issue_rd != AW'(REG_ZERO);
  assign w_dec       = w_wb_nz && (w_cnt[i_wb_rd] != '0);
  assign w_underflow = w_wb_nz && (w_cnt[i_wb_rd] == '0);
  assign w_sat       = w_iss_nz && (w_cnt[i_issue_rd] == '1);

  // A same-cycle retire of the saturated register leaves room for the new issue.
  assign o_issue_ready = !w_sat || (w_dec && (i_wb_rd == i_issue_rd));
  assign w_inc         = i_issue_valid && o_issue_ready && w_iss_nz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (w_inc && (i_issue_rd == AW'(r)) && !(w_dec && (i_wb_rd == AW'(r))))
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        else if (w_dec && (i_wb_rd == AW'(r)) && !(w_inc && (i_issue_rd == AW'(r))))
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
      if (w_underflow) r_err <= 1'b1;
    end
  end

  assign o_err_underflow = r_err;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
    assign o_rd_busy[k] = w_cnt[i_rd_addr[k*AW +: AW]] != '0;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: N combinational read ports, one write port, x0 hardwired
// to zero, optional write-to-read bypass, and an integrated RAW-hazard scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned NUM_READ = 2,
  parameter  int unsigned BYPASS   = 1,
  parameter  int unsigned CNT_W    = 2,
  localparam int unsigned AW       = calc_aw(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wb_valid,
  input  logic [AW-1:0]            i_wb_rd,
  input  logic [XLEN-1:0]          i_wb_data,
  input  logic [NUM_READ*AW-1:0]   i_rd_addr,
  output logic [NUM_READ*XLEN-1:0] o_rd_data,
  output logic [NUM_READ-1:0]      o_rd_busy,
  input  logic                     i_issue_valid,
  input  logic [AW-1:0]            i_issue_rd,
  output logic                     o_issue_ready,
  output logic                     o_err_underflow
);

  logic [XLEN-1:0] r_regs [NUM_REGS-1:1];
  logic [XLEN-1:0] w_regs [NUM_REGS];
  logic            w_we;

  assign w_we = i_wb_valid && (i_wb_rd != AW'(REG_ZERO));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (w_we && (i_wb_rd == AW'(r))) r_regs[r] <= i_wb_data;
      end
    end
  end

  assign w_regs[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg_view
    assign w_regs[g] = r_regs[g];
  end

  // Bypass is gated by reset so read data is all-zero while reset is held.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [AW-1:0] w_addr;
    logic          w_byp;
    assign w_addr = i_rd_addr[k*AW +: AW];
    assign w_byp  = (BYPASS != 0) && i_rst_n && i_wb_valid && (i_wb_rd == w_addr);
    assign o_rd_data[k*XLEN +: XLEN] = (w_addr == AW'(REG_ZERO)) ? '0 :
                                       w_byp                     ? i_wb_data :
                                                                   w_regs[w_addr];
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W),
    .NUM_READ (NUM_READ)
  ) u_scoreboard (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_wb_valid      (i_wb_valid),
    .i_wb_rd         (i_wb_rd),
    .i_issue_valid   (i_issue_valid),
    .i_issue_rd      (i_issue_rd),
    .i_rd_addr       (i_rd_addr),
    .o_rd_busy       (o_rd_busy),
    .o_issue_ready   (o_issue_ready),
    .o_err_underflow (o_err_underflow)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: BYPASS=1 and BYPASS=0 instances on shared stimulus,
// checked every cycle against an array/counter model plus directed literal checks.
module tb_reg_file_sb;

  localparam int MAXC = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbv;
  logic [4:0]  wbrd;
  logic [31:0] wbd;
  logic [9:0]  ra;
  logic        iv;
  logic [4:0]  ird;

  logic [63:0] rd1, rd0;
  logic [1:0]  busy1, busy0;
  logic        rdy1, rdy0, err1, err0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .BYPASS(1), .CNT_W(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_valid(wbv), .i_wb_rd(wbrd), .i_wb_data(wbd),
    .i_rd_addr(ra), .o_rd_data(rd1), .o_rd_busy(busy1), .i_issue_valid(iv),
    .i_issue_rd(ird), .o_issue_ready(rdy1), .o_err_underflow(err1)
  );

  reg_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_READ(2), .BYPASS(0), .CNT_W(2)) u_dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_valid(wbv), .i_wb_rd(wbrd), .i_wb_data(wbd),
    .i_rd_addr(ra), .o_rd_data(rd0), .o_rd_busy(busy0), .i_issue_valid(iv),
    .i_issue_rd(ird), .o_issue_ready(rdy0), .o_err_underflow(err0)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    return (ird == 0) || (m_cnt[ird] < MAXC) || (wbv && (wbrd == ird) && (m_cnt[ird] > 0));
  endfunction

  // Model: architectural state as plain arrays; same-register inc/dec nets out.
  always @(posedge clk or negedge rst_n) begin
    bit wb_nz, inc, dec;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_cnt[i]  = 0;
      end
      m_err = 1'b0;
    end else begin
      wb_nz = wbv && (wbrd != 0);
      inc   = iv && exp_ready() && (ird != 0);
      dec   = wb_nz && (m_cnt[wbrd] > 0);
      if (wb_nz && (m_cnt[wbrd] == 0)) m_err = 1'b1;
      if (inc) m_cnt[ird] = m_cnt[ird] + 1;
      if (dec) m_cnt[wbrd] = m_cnt[wbrd] - 1;
      if (wb_nz) m_regs[wbrd] = wbd;
    end
  end

  always @(negedge clk) begin
    logic [4:0]  a;
    logic [31:0] e0, e1;
    for (int k = 0; k < 2; k++) begin
      a  = ra[k*5 +: 5];
      e0 = (!rst_n || a == 0) ? 32'd0 : m_regs[a];
      e1 = (rst_n && a != 0 && wbv && wbrd == a) ? wbd : e0;
      check("rd_data_bypass", rd1[k*32 +: 32], e1);
      check("rd_data_nobypass", rd0[k*32 +: 32], e0);
      check("rd_busy", {31'd0, busy1[k]}, {31'd0, m_cnt[a] != 0});
    end
    check("issue_ready", {31'd0, rdy1}, {31'd0, exp_ready()});
    check("err_underflow", {31'd0, err1}, {31'd0, m_err});
  end

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic i, input logic [4:0] ir,
                       input logic [4:0] a0, input logic [4:0] a1);
    wbv = v; wbrd = r; wbd = d; iv = i; ird = ir; ra = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (3) tick();
    mid();
    check("reset_ready", {31'd0, rdy1}, 32'd1);
    check("reset_data", rd1[31:0], 32'd0);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      tick();
    end
    mid();
    check("post_reset_err", {31'd0, err1}, 32'd0);
    tick();

    // x7 write and read-back
    drive(0, 0, 0, 1, 7, 0, 0); tick();
    drive(1, 7, 32'hDEADBEEF, 0, 0, 7, 0); tick();
    drive(0, 0, 0, 0, 0, 7, 0); mid();
    check("x7_readback", rd1[31:0], 32'hDEADBEEF);
    tick();

    // x0 write discarded
    drive(1, 0, 32'h12345678, 0, 0, 0, 0); mid();
    check("x0_during_write", rd1[63:32], 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); mid();
    check("x0_after_write", rd1[31:0], 32'd0);
    tick();

    // bypass vs. no bypass on x3
    drive(0, 0, 0, 1, 3, 0, 0); tick(); tick();
    drive(1, 3, 32'h11111111, 0, 0, 0, 0); tick();
    drive(1, 3, 32'hA5A5A5A5, 0, 0, 0, 3); mid();
    check("bypass_same_cycle", rd1[63:32], 32'hA5A5A5A5);
    check("nobypass_old_value", rd0[63:32], 32'h11111111);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3); mid();
    check("nobypass_next_cycle", rd0[63:32], 32'hA5A5A5A5);
    tick();

    // saturate x9
    drive(0, 0, 0, 1, 9, 9, 0);
    repeat (3) tick();
    mid();
    check("x9_busy", {31'd0, busy1[0]}, 32'd1);
    check("x9_saturated_ready", {31'd0, rdy1}, 32'd0);
    tick();
    drive(1, 9, 32'h00000099, 1, 9, 9, 0); mid();
    check("x9_sat_with_wb_ready", {31'd0, rdy1}, 32'd1);
    tick();
    drive(1, 9, 32'h00000999, 0, 0, 9, 0);
    repeat (3) tick();
    drive(0, 0, 0, 0, 0, 9, 0); mid();
    check("x9_drained_busy", {31'd0, busy1[0]}, 32'd0);
    check("x9_data", rd1[31:0], 32'h00000999);
    tick();

    // x4 issue + writeback same cycle
    drive(0, 0, 0, 1, 4, 4, 0); tick();
    drive(1, 4, 32'h00000044, 1, 4, 4, 0); tick();
    drive(0, 0, 0, 0, 0, 4, 0); mid();
    check("x4_still_busy", {31'd0, busy1[0]}, 32'd1);
    check("x4_data", rd1[31:0], 32'h00000044);
    check("err_before_underflow", {31'd0, err1}, 32'd0);
    tick();

    // underflow on x12
    drive(1, 12, 32'hC0C0C0C0, 0, 0, 12, 0); mid();
    check("err_same_cycle", {31'd0, err1}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 12, 0); mid();
    check("err_set", {31'd0, err1}, 32'd1);
    check("x12_data", rd1[31:0], 32'hC0C0C0C0);
    tick();
    drive(1, 4, 32'h00000444, 1, 6, 4, 6);
    repeat (3) tick();
    drive(0, 0, 0, 0, 0, 0, 0); mid();
    check("err_sticky", {31'd0, err1}, 32'd1);
    tick();

    // reset mid-traffic with cnt[5]=2
    drive(0, 0, 0, 1, 5, 5, 5);
    repeat (3) tick();
    drive(1, 5, 32'h00000055, 0, 0, 5, 5); tick();
    drive(0, 0, 0, 1, 5, 5, 5); mid();
    check("x5_busy_pre_reset", {31'd0, busy1[0]}, 32'd1);
    check("x5_data_pre_reset", rd1[31:0], 32'h00000055);
    #1 rst_n = 1'b0;
    #1;
    check("x5_data_in_reset", rd1[31:0], 32'd0);
    check("x5_busy_in_reset", {31'd0, busy1[0]}, 32'd0);
    check("ready_in_reset", {31'd0, rdy1}, 32'd1);
    check("err_in_reset", {31'd0, err1}, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 5); mid();
    check("x5_busy_after_reset", {31'd0, busy1[0]}, 32'd0);
    tick();

    // random traffic on a small register window
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
